// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide execute unit.
package ex_muldiv_pkg;

    // Reset level used by every sequential block in this slice.
    localparam logic RstEnable = 1'b1;

    // Operation select carried on the op port.
    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    // Controller state encodings.
    localparam logic [1:0] MD_ST_IDLE = 2'b00;
    localparam logic [1:0] MD_ST_MUL  = 2'b01;
    localparam logic [1:0] MD_ST_DIV  = 2'b10;
    localparam logic [1:0] MD_ST_DONE = 2'b11;

    // Signed variants have op[0] clear.
    function automatic logic md_op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Divide variants have op[1] set.
    function automatic logic md_op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/ex_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not borrow.
module ex_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dividend_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_i, dividend_bit_i};
    assign diff    = shifted - {1'b0, divisor_i};

    // rem_i < divisor_i always holds, so shifted < 2*divisor and the top
    // bit of the difference is a reliable borrow flag.
    assign q_bit_o = ~diff[XLEN];
    assign rem_o   = q_bit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit next to the EX ALU. Produces HI/LO after
// XLEN iterations, stalls the front of the pipeline while working and
// accepts a flush through annul.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] DIV0_LO = '1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_1,
    input  logic [XLEN-1:0] operand_2,
    input  logic            annul,
    output logic            stall_req,
    output logic            busy,
    output logic            result_valid,
    output logic            div_zero,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d;      // multiplicand / dividend magnitude
    logic [XLEN-1:0]   b_q, b_d;      // multiplier / divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;  // product, or {remainder, quotient}
    logic              neg_q, neg_d;  // product / quotient sign
    logic              rneg_q, rneg_d; // remainder sign
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              dz_q, dz_d;

    logic              sign1, sign2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              go;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod_fix;

    logic [XLEN-1:0]   rem_next;
    logic              q_bit;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    assign sign1 = md_op_is_signed(op) & operand_1[XLEN-1];
    assign sign2 = md_op_is_signed(op) & operand_2[XLEN-1];
    assign mag1  = sign1 ? -operand_1 : operand_1;
    assign mag2  = sign2 ? -operand_2 : operand_2;
    assign go    = start & ~annul;

    // Right-shifting shift-add: the upper half accumulates, the low half
    // collects finished product bits as they shift out.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (b_q[0] ? a_q : '0)};
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign prod_fix = neg_q ? -mul_next : mul_next;

    ex_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_i          (acc_q[2*XLEN-1:XLEN]),
        .dividend_bit_i (a_q[XLEN-1]),
        .divisor_i      (b_q),
        .rem_o          (rem_next),
        .q_bit_o        (q_bit)
    );

    // Dividend bits are fed from a_q; quotient bits enter at the bottom of acc.
    assign div_next = {rem_next, acc_q[XLEN-2:0], q_bit};
    assign quo_fix  = neg_q  ? -div_next[XLEN-1:0]      : div_next[XLEN-1:0];
    assign rem_fix  = rneg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

    assign busy         = (state_q == MD_ST_MUL) || (state_q == MD_ST_DIV);
    assign result_valid = (state_q == MD_ST_DONE);
    assign stall_req    = ((state_q == MD_ST_IDLE) && go) || busy;
    assign div_zero     = dz_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

    // Next-state and datapath control for one iteration per cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;

        case (state_q)
            MD_ST_IDLE: begin
                if (go) begin
                    a_d    = mag1;
                    b_d    = mag2;
                    neg_d  = sign1 ^ sign2;
                    rneg_d = sign1;
                    acc_d  = '0;
                    cnt_d  = CW'(XLEN);
                    if (md_op_is_div(op)) begin
                        if (operand_2 == '0) begin
                            state_d = MD_ST_DONE;
                            cnt_d   = '0;
                            hi_d    = operand_1;
                            lo_d    = DIV0_LO;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = MD_ST_DIV;
                        end
                    end else begin
                        state_d = MD_ST_MUL;
                    end
                end
            end

            MD_ST_MUL: begin
                if (annul) begin
                    state_d = MD_ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = mul_next;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = MD_ST_DONE;
                        hi_d    = prod_fix[2*XLEN-1:XLEN];
                        lo_d    = prod_fix[XLEN-1:0];
                        dz_d    = 1'b0;
                    end
                end
            end

            MD_ST_DIV: begin
                if (annul) begin
                    state_d = MD_ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = div_next;
                    a_d   = a_q << 1;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = MD_ST_DONE;
                        hi_d    = rem_fix;
                        lo_d    = quo_fix;
                        dz_d    = 1'b0;
                    end
                end
            end

            MD_ST_DONE: begin
                state_d = MD_ST_IDLE;
            end

            default: begin
                state_d = MD_ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= MD_ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (XLEN=32): directed table, random ops
// against an arithmetic reference, and annul / reset sequences.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        annul;
    logic        stall_req;
    logic        busy;
    logic        result_valid;
    logic        div_zero;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    logic        last_dz = 1'b0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t tbl[$];

    ex_muldiv #(
        .XLEN    (32),
        .DIV0_LO (32'hFFFF_FFFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .operand_1    (operand_1),
        .operand_2    (operand_2),
        .annul        (annul),
        .stall_req    (stall_req),
        .busy         (busy),
        .result_valid (result_valid),
        .div_zero     (div_zero),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (o)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) begin
                    dz = 1'b1;
                    p  = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) begin
                    dz = 1'b1;
                    p  = {a, 32'hFFFF_FFFF};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Full transaction with start held through DONE, as the pipeline does.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        int done_cyc;
        int stall_miss;
        int exp_cyc;
        exp_cyc = (o[1] && b == 0) ? 1 : 33;
        @(negedge clk);
        start     = 1'b1;
        annul     = 1'b0;
        op        = o;
        operand_1 = a;
        operand_2 = b;
        #1;
        chk("stall_cycle0", stall_req, 1);
        done_cyc   = 0;
        stall_miss = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                done_cyc = c;
                break;
            end
            if (!stall_req || !busy) stall_miss++;
        end
        chk("done_cycle", done_cyc, exp_cyc);
        chk("stall_while_busy", stall_miss, 0);
        chk("hi", hi_o, ehi);
        chk("lo", lo_o, elo);
        chk("div_zero", div_zero, edz);
        chk("stall_in_done", stall_req, 0);
        @(posedge clk);
        #1;
        chk("no_restart_busy_valid", {busy, result_valid}, 2'b00);
        chk("hi_hold", hi_o, ehi);
        start   = 1'b0;
        last_hi = ehi;
        last_lo = elo;
        last_dz = edz;
    endtask

    initial begin
        logic [31:0] ra, rb, ehi, elo;
        logic        edz;
        logic [1:0]  ro;
        int          rv_seen;
        logic [31:0] specials [6];

        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        specials[5] = 32'h0000_0002;

        rst = 1'b1; start = 1'b0; annul = 1'b0; op = 2'b00;
        operand_1 = '0; operand_2 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", hi_o, 0);
        chk("reset_lo", lo_o, 0);
        chk("reset_flags", {div_zero, result_valid, busy, stall_req}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        tbl.push_back('{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
        tbl.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        tbl.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        tbl.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
        tbl.push_back('{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1});
        tbl.push_back('{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0});
        tbl.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
        tbl.push_back('{2'b00, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{2'b10, 32'h0000_0000, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1});
        tbl.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
        tbl.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0});
        for (int i = 0; i < tbl.size(); i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz);

        // Randomised ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            model(ro, ra, rb, ehi, elo, edz);
            run_op(ro, ra, rb, ehi, elo, edz);
        end

        // Annul in IDLE suppresses the start
        @(negedge clk);
        start = 1'b1; annul = 1'b1; op = 2'b01;
        operand_1 = 32'h1234_5678; operand_2 = 32'h0000_0003;
        #1;
        chk("idle_annul_stall", stall_req, 0);
        @(posedge clk);
        #1;
        chk("idle_annul_busy", busy, 0);
        start = 1'b0; annul = 1'b0;

        // Annul of a MULT in cycle 10
        @(negedge clk);
        start = 1'b1; op = 2'b00;
        operand_1 = $urandom; operand_2 = $urandom;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
        end
        chk("annul_busy_c10", busy, 1);
        annul = 1'b1;
        @(posedge clk);
        #1;
        chk("annul_c11_busy_stall_valid", {busy, stall_req, result_valid}, 3'b000);
        chk("annul_hi_kept", hi_o, last_hi);
        chk("annul_lo_kept", lo_o, last_lo);
        chk("annul_dz_kept", div_zero, last_dz);
        start = 1'b0; annul = 1'b0;
        rv_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (result_valid || busy) rv_seen++;
        end
        chk("annul_no_late_result", rv_seen, 0);

        // Reset in cycle 5 of a DIVU, after a divide-by-zero left flags set
        run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        start = 1'b1; op = 2'b11;
        operand_1 = 32'h0000_0064; operand_2 = 32'h0000_0007;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1; start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_hi", hi_o, 0);
        chk("rst_mid_lo", lo_o, 0);
        chk("rst_mid_flags", {div_zero, result_valid, busy, stall_req}, 4'b0000);
        rst = 1'b0;
        rv_seen = 0;
        for (int c = 0; c < 36; c++) begin
            @(posedge clk);
            #1;
            if (result_valid) rv_seen++;
        end
        chk("rst_no_result", rv_seen, 0);
        run_op(2'b01, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
